servo_seq_ctrl: RTL and testbench

SERVO_SEQ_CTRL -- requirements
Module: servo_seq_ctrl

---
 rtl/servo_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_servo_seq_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/servo_seq_ctrl.sv
// servo_seq_ctrl: waypoint FIFO plus sequencer that issues timed start/target PWM ratios to a servo controller
// Ports: clock, reset_n (async active-low); enable, flush, home_ratio; wp_valid/wp_ready/wp_ratio/wp_dwell
// waypoint push; start_pwm_ratio, target_pwm_ratio, pwm_enable to the servo; busy, fifo_count, seq_done status.
// Optional macro SERVO_SEQ_CLAMP_EN clamps issued ratios to [MIN_RATIO, MAX_RATIO].
module servo_seq_ctrl #(
  parameter int         DEPTH     = 8,
  parameter int         TICK_DIV  = 50000,
  parameter logic [7:0] MIN_RATIO = 8'd5,
  parameter logic [7:0] MAX_RATIO = 8'd25
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     flush,
  input  logic [7:0]               home_ratio,
  input  logic                     wp_valid,
  output logic                     wp_ready,
  input  logic [7:0]               wp_ratio,
  input  logic [15:0]              wp_dwell,
  output logic [7:0]               start_pwm_ratio,
  output logic [7:0]               target_pwm_ratio,
  output logic                     pwm_enable,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     seq_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TICK_DIV);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..16");
  end
  if (TICK_DIV < 2) begin : g_bad_tick
    $error("TICK_DIV must be at least 2");
  end
  if (MIN_RATIO > MAX_RATIO) begin : g_bad_clamp
    $error("MIN_RATIO must not exceed MAX_RATIO");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_mem_ratio [DEPTH];
  logic [15:0]   r_mem_dwell [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_tick;
  logic [15:0]   r_dwell;
  logic [7:0]    r_start, r_target;
  logic          r_issued;
  logic          w_push, w_pop, w_has_entry, w_dwell_zero, w_wrap;
  logic [7:0]    w_head_ratio, w_issue_ratio;

  assign wp_ready         = (r_count < CW'(DEPTH)) & ~flush & reset_n;
  assign w_push           = wp_valid & wp_ready;
  assign w_pop            = r_state == S_LOAD;
  assign w_has_entry      = r_count != '0;
  assign w_dwell_zero     = r_dwell == '0;
  assign w_wrap           = r_tick == TW'(TICK_DIV - 1);
  assign w_head_ratio     = r_mem_ratio[r_rd];
  assign fifo_count       = r_count;
  assign start_pwm_ratio  = r_start;
  assign target_pwm_ratio = r_target;
  assign pwm_enable       = enable & r_issued;

`ifdef SERVO_SEQ_CLAMP_EN
  assign w_issue_ratio = w_head_ratio < MIN_RATIO ? MIN_RATIO :
                         w_head_ratio > MAX_RATIO ? MAX_RATIO : w_head_ratio;
`else
  assign w_issue_ratio = w_head_ratio;
`endif

  // Entry storage needs no reset: only slots between rd and wr are ever read.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_ratio[r_wr] <= wp_ratio;
      r_mem_dwell[r_wr] <= wp_dwell;
    end
  end

  always_comb begin
    w_next   = r_state;
    busy     = r_state == S_LOAD || r_state == S_DWELL;
    seq_done = r_state == S_DONE;
    unique case (r_state)
      S_IDLE:  w_next = enable && w_has_entry ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = S_DWELL;
      // The exit check does not depend on enable; enable only freezes the counters.
      S_DWELL: w_next = !w_dwell_zero ? S_DWELL : enable && w_has_entry ? S_LOAD : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_tick   <= '0;
      r_dwell  <= '0;
      r_start  <= '0;
      r_target <= '0;
      r_issued <= 1'b0;
    end else if (flush) begin
      r_state  <= S_IDLE;
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_tick   <= '0;
      r_dwell  <= '0;
      r_start  <= home_ratio;
      r_target <= home_ratio;
      r_issued <= 1'b0;
    end else begin
      r_state <= w_next;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) begin
        r_rd     <= r_rd + AW'(1);
        r_start  <= r_issued ? r_target : home_ratio;
        r_target <= w_issue_ratio;
        r_dwell  <= r_mem_dwell[r_rd];
        r_tick   <= '0;
        r_issued <= 1'b1;
      end else if (r_state == S_DWELL && enable && !w_dwell_zero) begin
        r_tick <= w_wrap ? '0 : r_tick + TW'(1);
        if (w_wrap) r_dwell <= r_dwell - 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_servo_seq_ctrl.sv
// tb_servo_seq_ctrl: randomized and directed bench for servo_seq_ctrl against a transaction-level reference model
module tb_servo_seq_ctrl;
  localparam int DEPTH = 8;
  localparam int TICK  = 4;

  logic        clock = 0, reset_n = 0, enable = 0, flush = 0, wp_valid = 0;
  logic [7:0]  home_ratio = 0, wp_ratio = 0;
  logic [15:0] wp_dwell = 0;
  logic        wp_ready, pwm_enable, busy, seq_done;
  logic [7:0]  start_pwm_ratio, target_pwm_ratio;
  logic [3:0]  fifo_count;

  always #5 clock = ~clock;

  servo_seq_ctrl #(.DEPTH(DEPTH), .TICK_DIV(TICK)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .flush(flush), .home_ratio(home_ratio),
    .wp_valid(wp_valid), .wp_ready(wp_ready), .wp_ratio(wp_ratio), .wp_dwell(wp_dwell),
    .start_pwm_ratio(start_pwm_ratio), .target_pwm_ratio(target_pwm_ratio), .pwm_enable(pwm_enable),
    .busy(busy), .fifo_count(fifo_count), .seq_done(seq_done)
  );

  int n_chk = 0, n_bad = 0;
  int q_r[$], q_d[$];
  int ph, m_tgt, m_start, m_rem;
  bit m_issued;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int r);
`ifdef SERVO_SEQ_CLAMP_EN
    return r < 5 ? 5 : r > 25 ? 25 : r;
`else
    return r;
`endif
  endfunction

  task automatic model_reset();
    q_r.delete(); q_d.delete();
    ph = 0; m_tgt = 0; m_start = 0; m_rem = 0; m_issued = 0;
  endtask

  // Phase 0 idle, 1 load, 2 dwell, 3 done; m_rem is remaining dwell in clock cycles.
  task automatic model_update();
    int sz;
    bit push;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (flush) begin
      q_r.delete(); q_d.delete();
      ph = 0; m_issued = 0; m_tgt = home_ratio; m_start = home_ratio; m_rem = 0;
      return;
    end
    sz = q_r.size();
    push = wp_valid && sz < DEPTH;
    case (ph)
      0: if (enable && sz > 0) ph = 1;
      1: begin
        m_start = m_issued ? m_tgt : home_ratio;
        m_tgt = clamp(q_r.pop_front());
        m_rem = q_d.pop_front() * TICK;
        m_issued = 1;
        ph = 2;
      end
      2: if (m_rem == 0) ph = (enable && sz > 0) ? 1 : 3; else if (enable) m_rem--;
      default: ph = 0;
    endcase
    if (push) begin
      q_r.push_back(wp_ratio);
      q_d.push_back(wp_dwell);
    end
  endtask

  task automatic check_all();
    chk("wp_ready", wp_ready, reset_n && !flush && q_r.size() < DEPTH);
    chk("fifo_count", fifo_count, q_r.size());
    chk("target", target_pwm_ratio, m_tgt);
    chk("start", start_pwm_ratio, m_start);
    chk("pwm_enable", pwm_enable, enable && m_issued);
    chk("busy", busy, ph == 1 || ph == 2);
    chk("seq_done", seq_done, ph == 3);
  endtask

  task automatic step();
    #1 check_all();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 0;
    model_reset();
    repeat (cycles) step();
    reset_n = 1;
  endtask

  task automatic push(input int r, input int d);
    wp_valid = 1; wp_ratio = 8'(r); wp_dwell = 16'(d);
    step();
    wp_valid = 0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((busy || seq_done || fifo_count != 0) && c < 300) begin
      step();
      c++;
    end
    chk("idle_timeout", c < 300, 1);
  endtask

  initial begin
    int c;
    int last;
    @(negedge clock);
    do_reset(3);

    home_ratio = 20; enable = 1;
    push(50, 2);
    c = 0;
    while (!seq_done && c < 40) begin step(); c++; end
    chk("done_latency", c, 11);
    chk("first_target", target_pwm_ratio, clamp(50));
    chk("first_start", start_pwm_ratio, 20);
    step();
    chk("done_width", seq_done, 0);

    enable = 0;
    last = 0;
    for (int i = 0; i < DEPTH; i++) begin
      last = $urandom_range(0, 255);
      push(last, $urandom_range(0, 1));
    end
    chk("full_ready", wp_ready, 0);
    chk("full_count", fifo_count, DEPTH);
    enable = 1;
    wait_idle();
    chk("last_target", target_pwm_ratio, clamp(last));

    push(77, 3);
    c = 0;
    repeat (4) begin step(); c++; end
    enable = 0;
    repeat (10) begin step(); chk("pause_pwm", pwm_enable, 0); c++; end
    enable = 1;
    while (!seq_done && c < 60) begin step(); c++; end
    chk("pause_latency", c, 25);
    wait_idle();

    for (int i = 0; i < 4; i++) push($urandom_range(0, 255), 2);
    chk("pre_flush_count", fifo_count, 3);
    chk("pre_flush_busy", busy, 1);
    flush = 1; wp_valid = 1; home_ratio = 33;
    step();
    flush = 0; wp_valid = 0;
    chk("flush_count", fifo_count, 0);
    chk("flush_busy", busy, 0);
    chk("flush_target", target_pwm_ratio, 33);
    chk("flush_start", start_pwm_ratio, 33);
    chk("flush_pwm", pwm_enable, 0);
    chk("flush_done", seq_done, 0);
    step();

    push(0, 0);
    push(200, 0);
    wait_idle();
`ifdef SERVO_SEQ_CLAMP_EN
    chk("clamp_hi", target_pwm_ratio, 25);
    chk("clamp_lo", start_pwm_ratio, 5);
`else
    chk("clamp_hi", target_pwm_ratio, 200);
    chk("clamp_lo", start_pwm_ratio, 0);
`endif

    enable = 0;
    for (int i = 0; i < 3; i++) push(10 + i, 0);
    enable = 1;
    step();
    wp_valid = 1; wp_ratio = 13; wp_dwell = 0;
    step();
    wp_valid = 0;
    chk("pushpop_count", fifo_count, 3);
    chk("b2b_t0", target_pwm_ratio, clamp(10));
    step(); step();
    chk("b2b_t1", target_pwm_ratio, clamp(11));
    step(); step();
    chk("b2b_t2", target_pwm_ratio, clamp(12));
    wait_idle();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset(2);
      enable = $urandom_range(0, 9) != 0;
      flush = $urandom_range(0, 149) == 0;
      wp_valid = $urandom_range(0, 2) == 0;
      wp_ratio = 8'($urandom_range(0, 255));
      wp_dwell = 16'($urandom_range(0, 2));
      if ($urandom_range(0, 49) == 0) home_ratio = 8'($urandom_range(0, 255));
      step();
    end
    flush = 0; wp_valid = 0;
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
